// File: rtl/shift_arbiter.sv
// Two-requester arbiter sharing one 32-bit barrel shifter. The granted
// operation is shifted combinationally and registered into a single output
// slot tagged with the requester id. The slot drains through a valid/ready
// response handshake and can be refilled in the same cycle it drains.

// Barrel shifter. Left shifts reuse the right-shift stages by reversing
// the bit order on the way in and on the way out.
module shift_mux (
    input  logic [31:0] data_i,
    input  logic [4:0]  sa_i,
    input  logic        right_i,
    input  logic        arith_i,
    output logic [31:0] result_o
);

    function automatic logic [31:0] bit_reverse(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    logic        fill;
    logic [31:0] src;
    logic [31:0] st1;
    logic [31:0] st2;
    logic [31:0] st4;
    logic [31:0] st8;
    logic [31:0] st16;

    // Five logarithmic right-shift stages; fill bit is the sign only for
    // arithmetic right shifts, zero otherwise.
    always_comb begin
        fill     = right_i & arith_i & data_i[31];
        src      = right_i ? data_i : bit_reverse(data_i);
        st1      = sa_i[0] ? {fill, src[31:1]}          : src;
        st2      = sa_i[1] ? {{2{fill}},  st1[31:2]}    : st1;
        st4      = sa_i[2] ? {{4{fill}},  st2[31:4]}    : st2;
        st8      = sa_i[3] ? {{8{fill}},  st4[31:8]}    : st4;
        st16     = sa_i[4] ? {{16{fill}}, st8[31:16]}   : st8;
        result_o = right_i ? st16 : bit_reverse(st16);
    end

endmodule

// Slot FSM:
//   state      | meaning
//   SLOT_EMPTY | no result held, resp_valid low
//   SLOT_FULL  | result held in resp_data/resp_id, resp_valid high
module shift_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_data,
    input  logic [4:0]       req0_sa,
    input  logic             req0_right,
    input  logic             req0_arith,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_data,
    input  logic [4:0]       req1_sa,
    input  logic             req1_right,
    input  logic             req1_arith,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic             resp_id,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    slot_state_t      state_q;
    slot_state_t      state_d;
    logic [31:0]      resp_data_q;
    logic             resp_id_q;
    logic             last_grant_q;
    logic [CNT_W-1:0] op_count_q;

    logic             can_accept;
    logic             gnt_any;
    logic             gnt_id;
    logic             accept;
    logic             consume;

    logic [31:0]      sh_data;
    logic [4:0]       sh_sa;
    logic             sh_right;
    logic             sh_arith;
    logic [31:0]      sh_result;

    // Round-robin grant: a lone valid wins outright; on contention the
    // requester that did not win the last accept goes first.
    always_comb begin
        gnt_any = req0_valid | req1_valid;
        gnt_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt_id = ~last_grant_q;
        end else if (req1_valid) begin
            gnt_id = 1'b1;
        end
    end

    // The slot can take a new result when empty or when it drains this
    // cycle; reset forces both readys low.
    always_comb begin
        can_accept = clrn & ((state_q == SLOT_EMPTY) | resp_ready);
        req0_ready = can_accept & gnt_any & ~gnt_id;
        req1_ready = can_accept & gnt_any &  gnt_id;
        accept     = req0_ready | req1_ready;
        consume    = (state_q == SLOT_FULL) & resp_ready;
    end

    // Steer the granted requester's operands into the shared shifter.
    always_comb begin
        if (gnt_id) begin
            sh_data  = req1_data;
            sh_sa    = req1_sa;
            sh_right = req1_right;
            sh_arith = req1_arith;
        end else begin
            sh_data  = req0_data;
            sh_sa    = req0_sa;
            sh_right = req0_right;
            sh_arith = req0_arith;
        end
    end

    shift_mux u_shift_mux (
        .data_i   (sh_data),
        .sa_i     (sh_sa),
        .right_i  (sh_right),
        .arith_i  (sh_arith),
        .result_o (sh_result)
    );

    // Slot next-state: fill on accept, drain only when nothing refills it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SLOT_EMPTY: begin
                if (accept) begin
                    state_d = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                if (resp_ready && !accept) begin
                    state_d = SLOT_EMPTY;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
    end

    // Slot state register.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Result slot and arbitration history; both change only on an accept.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            resp_data_q  <= 32'h0;
            resp_id_q    <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (accept) begin
            resp_data_q  <= sh_result;
            resp_id_q    <= gnt_id;
            last_grant_q <= gnt_id;
        end
    end

    // Count consumed results; wraps silently.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            op_count_q <= '0;
        end else if (consume) begin
            op_count_q <= op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign resp_valid = (state_q == SLOT_FULL);
    assign resp_data  = resp_data_q;
    assign resp_id    = resp_id_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter with a reference model and a result
// scoreboard; inputs change on the falling edge.
module tb_shift_arbiter;

    localparam int CNT_W = 4;

    logic             clk;
    logic             clrn;
    logic             req0_valid, req0_ready, req0_right, req0_arith;
    logic [31:0]      req0_data;
    logic [4:0]       req0_sa;
    logic             req1_valid, req1_ready, req1_right, req1_arith;
    logic [31:0]      req1_data;
    logic [4:0]       req1_sa;
    logic             resp_valid, resp_ready, resp_id;
    logic [31:0]      resp_data;
    logic [CNT_W-1:0] op_count;

    shift_arbiter #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_sa    (req0_sa),
        .req0_right (req0_right),
        .req0_arith (req0_arith),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_sa    (req1_sa),
        .req1_right (req1_right),
        .req1_arith (req1_arith),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   m_known = 0;
    bit   m_full  = 0;
    bit   m_last  = 1;
    int   m_cnt   = 0;

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s,
                                              input logic r, input logic a);
        if (!r)     return d << s;
        else if (a) return $unsigned($signed(d) >>> s);
        else        return d >> s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic drv0(input bit v, input logic [31:0] d, input logic [4:0] s, input bit r, input bit a);
        req0_valid = v; req0_data = d; req0_sa = s; req0_right = r; req0_arith = a;
    endtask

    task automatic drv1(input bit v, input logic [31:0] d, input logic [4:0] s, input bit r, input bit a);
        req1_valid = v; req1_data = d; req1_sa = s; req1_right = r; req1_arith = a;
    endtask

    // One clock: check combinational outputs against the model before the
    // edge, update model and scoreboard, then check registered state after.
    task automatic tick();
        bit   can, g0, g1;
        exp_t e;
        #2;
        can = clrn && (!m_full || resp_ready);
        g0  = req0_valid && (!req1_valid || m_last);
        g1  = req1_valid && (!req0_valid || !m_last);
        chk("req0_ready", 32'(req0_ready), 32'(can && g0));
        chk("req1_ready", 32'(req1_ready), 32'(can && g1));
        chk("both_ready", 32'(req0_ready & req1_ready), 32'd0);
        if (m_known) chk("resp_valid_pre", 32'(resp_valid), 32'(m_full));
        if (!clrn) begin
            exp_q.delete();
            m_full  = 0;
            m_last  = 1;
            m_cnt   = 0;
            m_known = 1;
        end else begin
            if (m_full && resp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_data", resp_data, e.data);
                    chk("resp_id", 32'(resp_id), 32'(e.id));
                end
                m_cnt++;
            end
            if (can && (g0 || g1)) begin
                e.id   = g1;
                e.data = g1 ? ref_shift(req1_data, req1_sa, req1_right, req1_arith)
                            : ref_shift(req0_data, req0_sa, req0_right, req0_arith);
                exp_q.push_back(e);
                m_full = 1;
                m_last = g1;
            end else if (resp_ready) begin
                m_full = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("op_count", 32'(op_count), 32'(m_cnt & ((1 << CNT_W) - 1)));
        chk("resp_valid_post", 32'(resp_valid), 32'(m_full));
    endtask

    logic [31:0] hold_data;
    logic        hold_id;

    initial begin
        clrn = 1'b0;
        resp_ready = 1'b0;
        drv0(0, 32'h0, 5'd0, 0, 0);
        drv1(0, 32'h0, 5'd0, 0, 0);

        // Reset
        tick();
        chk("rst_resp_data", resp_data, 32'h0);
        chk("rst_resp_id", 32'(resp_id), 32'd0);

        // Single requests and shift corner cases
        clrn = 1'b1; resp_ready = 1'b1;
        drv0(1, 32'h8000_0000, 5'd4, 1, 1);
        tick();
        chk("sra_data", resp_data, 32'hF800_0000);
        chk("sra_id", 32'(resp_id), 32'd0);
        drv0(0, 32'h0, 5'd0, 0, 0);
        drv1(1, 32'h8000_0000, 5'd4, 1, 0);
        tick();
        chk("srl_data", resp_data, 32'h0800_0000);
        chk("srl_id", 32'(resp_id), 32'd1);
        drv1(0, 32'h0, 5'd0, 0, 0);
        drv0(1, 32'h0000_0001, 5'd31, 0, 1);
        tick();
        chk("sll31_data", resp_data, 32'h8000_0000);
        drv0(0, 32'h0, 5'd0, 0, 0);
        drv1(1, 32'h9234_5678, 5'd0, 1, 1);
        tick();
        chk("sa0_data", resp_data, 32'h9234_5678);

        // Contention, no back-pressure: strict alternation starting at 0
        for (int i = 0; i < 6; i++) begin
            drv0(1, $urandom, 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
            drv1(1, $urandom, 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
            tick();
            chk("rr_id", 32'(resp_id), 32'(i % 2));
        end

        // Back-pressure: slot holds, readys low
        hold_data = resp_data;
        hold_id   = resp_id;
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_data", resp_data, hold_data);
            chk("bp_id", 32'(resp_id), 32'(hold_id));
        end
        // Release: pass-through accept in the same cycle
        resp_ready = 1'b1;
        tick();
        chk("pass_valid", 32'(resp_valid), 32'd1);
        drv0(0, 32'h0, 5'd0, 0, 0);
        drv1(0, 32'h0, 5'd0, 0, 0);
        tick();

        // Reset mid-operation with op_count at 5
        clrn = 1'b0;
        tick();
        clrn = 1'b1;
        drv0(1, 32'h0000_00F0, 5'd2, 1, 0);
        for (int i = 0; i < 6; i++) tick();
        chk("cnt5", 32'(op_count), 32'd5);
        drv1(1, 32'hFFFF_0000, 5'd8, 1, 1);
        resp_ready = 1'b0;
        clrn = 1'b0;
        tick();
        chk("midrst_valid", 32'(resp_valid), 32'd0);
        chk("midrst_cnt", 32'(op_count), 32'd0);
        chk("midrst_data", resp_data, 32'h0);
        clrn = 1'b1;
        resp_ready = 1'b1;
        tick();
        chk("first_after_rst", 32'(resp_id), 32'd0);

        // Counter wrap at CNT_W=4
        drv1(0, 32'h0, 5'd0, 0, 0);
        clrn = 1'b0;
        tick();
        clrn = 1'b1;
        drv0(1, 32'h0000_0003, 5'd1, 0, 0);
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (k - 1 == 15) chk("wrap15", 32'(op_count), 32'd15);
            if (k - 1 == 16) chk("wrap16", 32'(op_count), 32'd0);
            if (k - 1 == 17) chk("wrap17", 32'(op_count), 32'd1);
        end

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            drv0(1'($urandom), $urandom, 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
            drv1(1'($urandom), $urandom, 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
            resp_ready = 1'($urandom);
            tick();
        end
        drv0(0, 32'h0, 5'd0, 0, 0);
        drv1(0, 32'h0, 5'd0, 0, 0);
        resp_ready = 1'b1;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one combinational 32-bit barrel shifter (shift_mux) between two requesters: req 0 is the ALU issue path, req 1 is the multiply/divide sequencer.
- Each requester uses a valid/ready handshake. Contested cycles are granted round-robin.
- The shift result is registered into a single output slot tagged with the requester id. That slot drains through a valid/ready response handshake.
- Throughput is one shift per cycle when the output is not back-pressured.

Parameters:
- CNT_W, 16, width of the completed-operation counter op_count.

Ports:
- clk  in  1  clock; all state updates on rising edge
- clrn  in  1  synchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_data  in  32  operand to shift
- req0_sa  in  5  shift amount 0..31
- req0_right  in  1  1 = right, 0 = left
- req0_arith  in  1  1 = arithmetic (right only), 0 = logical
- req1_valid, req1_ready, req1_data, req1_sa, req1_right, req1_arith  same as requester 0, for requester 1
- resp_valid  out  1  output slot holds a result
- resp_ready  in  1  consumer takes result this cycle
- resp_data  out  32  shift result
- resp_id  out  1  requester that owns resp_data
- op_count  out  CNT_W  number of results consumed

Behaviour:
- Synchronous reset (clrn=0 at a clock edge):
  - resp_valid=0, resp_data=0, resp_id=0, op_count=0.
  - last_grant=1, so requester 0 wins the first contest.
  - Any result held in the slot is discarded.
  - While clrn=0: req0_ready=0 and req1_ready=0.
- Slot states:
  - EMPTY (resp_valid=0) -> FULL on accept.
  - FULL -> EMPTY when resp_ready=1 and there is no accept that cycle.
  - FULL -> FULL when resp_ready=1 and there is an accept in the same cycle (pass-through, no bubble).
  - FULL with resp_ready=0: hold resp_data and resp_id unchanged.
- can_accept = clrn & (~resp_valid | resp_ready).
- Grant, combinational:
  - Only one valid: that requester is granted.
  - Both valid: the requester != last_grant is granted.
  - Neither valid: no grant.
  - reqN_ready = can_accept & grant==N. At most one ready is high in any cycle.
  - A ready never depends on the other requester's ready.
- Accept, at the edge with reqN_valid & reqN_ready:
  - Operands of N drive the shifter.
  - resp_data <= shift result; resp_id <= N; resp_valid <= 1; last_grant <= N.
  - Latency: accepted at edge k, result visible from edge k to edge k+1 (one cycle).
- last_grant updates only on an accept. Idle cycles and stalls keep the previous value.
- Shift arithmetic:
  - Left: zero fill, arith ignored.
  - Right with arith=1: fill with data[31]. Right with arith=0: zero fill.
  - sa=0: data passes through unchanged.
- op_count:
  - Increments by 1 on every cycle with resp_valid & resp_ready.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
- Requesters must hold their operands stable while valid is high and ready is low. The arbiter does not latch unaccepted operands.
- Starvation bound: a continuously valid requester is granted within 2 accepts.

Test Plan:
- Reset, then req0 alone: data=0x80000000, sa=4, right=1, arith=1 -> req0_ready=1 that cycle; next cycle resp_valid=1, resp_data=0xF8000000, resp_id=0.
- Same operand with arith=0 from req1 -> resp_data=0x08000000, resp_id=1. Left shift data=0x00000001, sa=31 -> 0x80000000. sa=0 -> data unchanged.
- Both requesters valid every cycle with resp_ready=1 for 6 cycles -> resp_id sequence 0,1,0,1,0,1; one result per cycle; never both readys high.
- Back-pressure:
  - Slot FULL with resp_ready=0 for 3 cycles and both requesters valid -> both readys low; resp_data/resp_id stable.
  - resp_ready goes high -> pass-through accept in the same cycle.
- Reset mid-operation: slot FULL, op_count=5, clrn=0 for one edge -> resp_valid=0, op_count=0, readys low during reset. First accept after reset goes to req0 even if both are valid.
- Counter wrap with CNT_W=4: 17 consumed results -> op_count reads 15 after the 15th, 0 after the 16th, 1 after the 17th.
